// File: rtl/sfifo_wrr_sched_if.sv
// Bus between the weighted round-robin read scheduler and its surroundings.
// The FIFO controllers and the egress control drive the master side.
// The scheduler is the slave side.
interface sfifo_wrr_sched_if #(
  parameter int NQ       = 4,
  parameter int QID_BITS = 2,
  parameter int WT_BITS  = 4
);
  logic                   enable;
  logic                   dst_ready;
  logic [NQ-1:0]          q_empty;
  logic [NQ*WT_BITS-1:0]  q_weight;
  logic [NQ-1:0]          q_rd;
  logic [QID_BITS-1:0]    grant_qid;
  logic                   busy;
  logic                   rd_valid;
  logic [QID_BITS-1:0]    rd_qid;

  modport master (
    output enable, dst_ready, q_empty, q_weight,
    input  q_rd, grant_qid, busy, rd_valid, rd_qid
  );

  modport slave (
    input  enable, dst_ready, q_empty, q_weight,
    output q_rd, grant_qid, busy, rd_valid, rd_qid
  );
endinterface

// File: rtl/sfifo_wrr_sched.sv
// Weighted round-robin read scheduler for NQ synchronous FIFOs.
// A granted queue is served for up to its weight in reads. The scheduler
// then spends one IDLE cycle and rotates to the next eligible queue.
// rd_valid/rd_qid line up with the registered FIFO read data.
module sfifo_wrr_sched #(
  parameter int NQ       = 4,
  parameter int QID_BITS = 2,
  parameter int WT_BITS  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  sfifo_wrr_sched_if.slave  bus
);

  typedef enum logic {IDLE, SERVE} state_t;

  state_t              state_q, state_d;
  logic [QID_BITS-1:0] grant_qid_q, grant_qid_d;
  logic [QID_BITS-1:0] rr_ptr_q, rr_ptr_d;
  logic [QID_BITS-1:0] rd_qid_q, rd_qid_d;
  logic [WT_BITS-1:0]  credit_q, credit_d;
  logic                busy_q, busy_d;
  logic                rd_valid_q, rd_valid_d;

  logic [WT_BITS-1:0]  weight [NQ];
  logic [NQ-1:0]       eligible;
  logic [NQ-1:0]       q_rd;
  logic                rd_fire;
  logic                sel_found;
  logic [QID_BITS-1:0] sel_qid;
  logic [QID_BITS:0]   scan_sum;
  logic [QID_BITS-1:0] scan_idx;
  logic [QID_BITS-1:0] next_ptr;

  // Unpack the weights. A queue is eligible when it has data and a nonzero weight.
  generate
    for (genvar gi = 0; gi < NQ; gi++) begin : g_elig
      assign weight[gi]   = bus.q_weight[gi*WT_BITS +: WT_BITS];
      assign eligible[gi] = ~bus.q_empty[gi] & (weight[gi] != '0);
    end
  endgenerate

  // Find the first eligible queue, starting at rr_ptr and wrapping at NQ-1.
  always_comb begin
    sel_found = 1'b0;
    sel_qid   = '0;
    scan_sum  = '0;
    scan_idx  = '0;
    for (int k = 0; k < NQ; k++) begin
      scan_sum = {1'b0, rr_ptr_q} + (QID_BITS+1)'(k);
      if (scan_sum >= (QID_BITS+1)'(NQ)) begin
        scan_sum = scan_sum - (QID_BITS+1)'(NQ);
      end
      scan_idx = scan_sum[QID_BITS-1:0];
      if (!sel_found && eligible[scan_idx]) begin
        sel_found = 1'b1;
        sel_qid   = scan_idx;
      end
    end
  end

  // Read strobe: only in SERVE, and only to the granted queue when it has data.
  always_comb begin
    q_rd = '0;
    if (state_q == SERVE && bus.enable && bus.dst_ready && !bus.q_empty[grant_qid_q]) begin
      q_rd[grant_qid_q] = 1'b1;
    end
  end

  assign rd_fire  = |q_rd;
  assign next_ptr = (grant_qid_q == QID_BITS'(NQ-1)) ? '0 : grant_qid_q + 1'b1;

  // Next-state logic for grant, credit and rotation.
  always_comb begin
    state_d     = state_q;
    grant_qid_d = grant_qid_q;
    credit_d    = credit_q;
    rr_ptr_d    = rr_ptr_q;
    case (state_q)
      IDLE: begin
        if (bus.enable && sel_found) begin
          state_d     = SERVE;
          grant_qid_d = sel_qid;
          credit_d    = weight[sel_qid];
        end
      end
      SERVE: begin
        if (rd_fire) begin
          credit_d = credit_q - 1'b1;
          if (credit_q == WT_BITS'(1)) begin
            state_d  = IDLE;
            rr_ptr_d = next_ptr;
          end
        end else if (!bus.enable || bus.q_empty[grant_qid_q]) begin
          // Any credit left over is discarded.
          state_d  = IDLE;
          rr_ptr_d = next_ptr;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d     = (state_d == SERVE);
    rd_valid_d = rd_fire;
    rd_qid_d   = rd_fire ? grant_qid_q : rd_qid_q;
  end

  // All scheduler state, with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      grant_qid_q <= '0;
      credit_q    <= '0;
      rr_ptr_q    <= '0;
      busy_q      <= 1'b0;
      rd_valid_q  <= 1'b0;
      rd_qid_q    <= '0;
    end else begin
      state_q     <= state_d;
      grant_qid_q <= grant_qid_d;
      credit_q    <= credit_d;
      rr_ptr_q    <= rr_ptr_d;
      busy_q      <= busy_d;
      rd_valid_q  <= rd_valid_d;
      rd_qid_q    <= rd_qid_d;
    end
  end

  assign bus.q_rd      = q_rd;
  assign bus.grant_qid = grant_qid_q;
  assign bus.busy      = busy_q;
  assign bus.rd_valid  = rd_valid_q;
  assign bus.rd_qid    = rd_qid_q;

endmodule

// File: tb/tb_sfifo_wrr_sched.sv
// Testbench for sfifo_wrr_sched.
// FIFO occupancies are held as counts. A reference model of the scheduling
// rules predicts the reads, grants and registered outputs for every cycle.
module tb_sfifo_wrr_sched;
  localparam int NQ = 4;
  localparam int QB = 2;
  localparam int WB = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sfifo_wrr_sched_if #(.NQ(NQ), .QID_BITS(QB), .WT_BITS(WB)) bus ();

  sfifo_wrr_sched #(.NQ(NQ), .QID_BITS(QB), .WT_BITS(WB)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Environment: FIFO occupancy, weights and control inputs.
  int cnt [NQ];
  int wt  [NQ];
  bit en_r, rdy_r;
  int push_pct;
  int cyc;

  // Reference model.
  bit m_serving;
  int m_grant, m_left, m_ptr;
  bit m_vld;
  int m_qid;
  bit prev_busy;

  // Logs of what the DUT actually did.
  int obs_reads [$];
  int obs_grants [$];

  task automatic chk(string tag, int obs, int exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < NQ; i++) begin
      bus.q_empty[i] = (cnt[i] == 0);
      bus.q_weight[i*WB +: WB] = WB'(wt[i]);
    end
    bus.enable    = en_r;
    bus.dst_ready = rdy_r;
  endtask

  task automatic model_reset();
    m_serving = 1'b0;
    m_grant   = 0;
    m_left    = 0;
    m_ptr     = 0;
    m_vld     = 1'b0;
    m_qid     = 0;
    prev_busy = 1'b0;
    obs_reads.delete();
    obs_grants.delete();
  endtask

  task automatic leave();
    m_serving = 1'b0;
    m_ptr     = (m_grant + 1) % NQ;
  endtask

  // Hold reset through two clock edges, check the reset values, then release at a negedge.
  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_q_rd", int'(bus.q_rd), 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_grant", bus.grant_qid, 0);
    chk("rst_rd_valid", bus.rd_valid, 0);
    chk("rst_rd_qid", bus.rd_qid, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  // One cycle, entered and left at a negedge. Drive the inputs and check the
  // outputs against the model. Then advance the model and the FIFO counts.
  task automatic step();
    int exp_rd;
    int pick;
    int q;
    drive();
    #1;
    exp_rd = -1;
    if (m_serving && en_r && rdy_r && cnt[m_grant] > 0) exp_rd = m_grant;
    chk("q_rd", int'(bus.q_rd), (exp_rd >= 0) ? (1 << exp_rd) : 0);
    chk("busy", bus.busy, int'(m_serving));
    chk("grant_qid", bus.grant_qid, m_grant);
    chk("rd_valid", bus.rd_valid, int'(m_vld));
    chk("rd_qid", bus.rd_qid, m_qid);
    for (int i = 0; i < NQ; i++) begin
      if (bus.q_rd[i]) begin
        obs_reads.push_back(i);
        $display("cycle %0d: read q%0d (grant %0d)", cyc, i, bus.grant_qid);
      end
    end
    if (bus.busy && !prev_busy) obs_grants.push_back(int'(bus.grant_qid));
    prev_busy = bus.busy;

    m_vld = (exp_rd >= 0);
    if (exp_rd >= 0) m_qid = exp_rd;
    if (!m_serving) begin
      pick = -1;
      if (en_r) begin
        for (int k = 0; k < NQ; k++) begin
          q = (m_ptr + k) % NQ;
          if (pick < 0 && cnt[q] > 0 && wt[q] > 0) pick = q;
        end
      end
      if (pick >= 0) begin
        m_serving = 1'b1;
        m_grant   = pick;
        m_left    = wt[pick];
      end
    end else if (exp_rd >= 0) begin
      m_left--;
      if (m_left == 0) leave();
    end else if (!en_r || cnt[m_grant] == 0) begin
      leave();
    end
    if (exp_rd >= 0) cnt[exp_rd]--;
    for (int i = 0; i < NQ; i++) begin
      if (cnt[i] < 15 && int'($urandom_range(0, 99)) < push_pct) cnt[i]++;
    end
    @(negedge clk);
    cyc++;
  endtask

  task automatic setup(int c0, int c1, int c2, int c3, int w0, int w1, int w2, int w3);
    cnt[0] = c0; cnt[1] = c1; cnt[2] = c2; cnt[3] = c3;
    wt[0] = w0;  wt[1] = w1;  wt[2] = w2;  wt[3] = w3;
    en_r = 1'b1; rdy_r = 1'b1; push_pct = 0;
  endtask

  initial begin
    int pat [8];
    int n0, n1, n2, n3;
    cyc = 0;
    bus.enable = 1'b0;
    bus.dst_ready = 1'b0;
    bus.q_empty = '1;
    bus.q_weight = '0;
    setup(0, 0, 0, 0, 0, 0, 0, 0);
    model_reset();
    @(negedge clk);

    // 1: equal weights 2, four entries each: grants 0..3 twice, pairs of reads.
    $display("scenario: equal weights");
    setup(4, 4, 4, 4, 2, 2, 2, 2);
    do_reset();
    repeat (30) step();
    chk("s1_nreads", obs_reads.size(), 16);
    for (int i = 0; i < 16; i++)
      chk("s1_rd_seq", (i < obs_reads.size()) ? obs_reads[i] : -1, (i / 2) % 4);
    for (int i = 0; i < 8; i++)
      chk("s1_grant_seq", (i < obs_grants.size()) ? obs_grants[i] : -1, i % 4);

    // 2: weights {3,1,0,2}: two full rounds of 9 cycles each.
    $display("scenario: weights 3,1,0,2");
    setup(15, 15, 15, 15, 3, 1, 0, 2);
    do_reset();
    repeat (18) step();
    n0 = 0; n1 = 0; n2 = 0; n3 = 0;
    foreach (obs_reads[i]) begin
      if (obs_reads[i] == 0) n0++;
      if (obs_reads[i] == 1) n1++;
      if (obs_reads[i] == 2) n2++;
      if (obs_reads[i] == 3) n3++;
    end
    chk("s2_q0_reads", n0, 6);
    chk("s2_q1_reads", n1, 2);
    chk("s2_q2_reads", n2, 0);
    chk("s2_q3_reads", n3, 4);

    // 3: queue 1 has a single entry and weight 4. The scheduler exits on empty and moves to queue 2.
    $display("scenario: empty mid-burst");
    setup(0, 1, 4, 0, 1, 4, 1, 1);
    do_reset();
    repeat (4) step();
    chk("s3_nreads", obs_reads.size(), 1);
    chk("s3_next_grant", bus.grant_qid, 2);
    repeat (3) step();

    // 4: dst_ready pattern during a weight-3 burst.
    $display("scenario: dst_ready stalls");
    setup(8, 0, 0, 0, 3, 0, 0, 0);
    do_reset();
    pat = '{1, 1, 0, 0, 1, 1, 1, 1};
    for (int i = 0; i < 8; i++) begin
      rdy_r = pat[i][0];
      step();
      if (i == 5) chk("s4_reads_in_burst", obs_reads.size(), 3);
    end

    // 5: enable dropped after the first of three reads. Re-enabling grants the next queue.
    $display("scenario: enable drop");
    setup(10, 10, 10, 10, 3, 3, 3, 3);
    do_reset();
    step();
    step();
    en_r = 1'b0;
    step();
    chk("s5_reads_before_drop", obs_reads.size(), 1);
    en_r = 1'b1;
    step();
    chk("s5_reenable_grant", bus.grant_qid, 1);
    repeat (4) step();

    // 6: asynchronous reset in the middle of a burst.
    $display("scenario: reset mid-burst");
    setup(10, 10, 10, 10, 3, 3, 3, 3);
    do_reset();
    step();
    step();
    #2;
    chk("s6_pre_reset_rd", int'(bus.q_rd != '0), 1);
    rst_n = 1'b0;
    #1;
    chk("s6_async_q_rd", int'(bus.q_rd), 0);
    chk("s6_async_busy", bus.busy, 0);
    chk("s6_async_rd_valid", bus.rd_valid, 0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    step();
    chk("s6_post_reset_grant", bus.grant_qid, 0);
    repeat (4) step();

    // 7: random traffic, enable, ready and weight changes.
    $display("scenario: random");
    setup(0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < NQ; i++) begin
      cnt[i] = $urandom_range(0, 6);
      wt[i]  = $urandom_range(1, 4);
    end
    push_pct = 30;
    do_reset();
    for (int n = 0; n < 1500; n++) begin
      en_r  = ($urandom_range(0, 9) != 0);
      rdy_r = ($urandom_range(0, 9) < 7);
      if ($urandom_range(0, 19) == 0) wt[$urandom_range(0, NQ-1)] = $urandom_range(0, 15);
      if (n == 750) do_reset();
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/sfifo_wrr_sched.md
# sfifo_wrr_sched

Weighted round-robin read scheduler that shares one downstream read path among NQ synchronous FIFOs built on the team's FIFO control block. Each cycle it issues at most one read strobe to the currently granted queue and serves up to a per-queue weight of entries before rotating to the next non-empty queue. It sits between the per-queue FIFO controllers and the shared egress datapath, which selects FIFO read data using the registered queue ID.

## Interface
- NQ, 4: number of queues, 2..16
- QID_BITS, 2: width of queue index; ceil(log2(NQ))
- WT_BITS, 4: width of each per-queue weight and of the credit counter
- clk  in  1  clock; all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- enable  in  1  scheduler enable; low forces no reads
- dst_ready  in  1  downstream can accept one entry this cycle
- q_empty  in  NQ  registered empty flag from each FIFO controller, bit i = queue i
- q_weight  in  NQ*WT_BITS  weight of queue i in bits [i*WT_BITS +: WT_BITS]; 0 = queue masked
- q_rd  out  NQ  one-hot-or-zero read strobe to the FIFO controllers (combinational from state and inputs)
- grant_qid  out  QID_BITS  queue currently granted (registered)
- busy  out  1  high in SERVE state (registered)
- rd_valid  out  1  one entry from queue rd_qid appears on the FIFO read data this cycle (registered)
- rd_qid  out  QID_BITS  queue index for rd_valid (registered)

## Operation
- States: IDLE, SERVE. Registers: state, grant_qid, credit[WT_BITS-1:0], rr_ptr[QID_BITS-1:0] (first queue to consider next), rd_valid, rd_qid.
- eligible[i] = ~q_empty[i] & (q_weight[i] != 0).
- IDLE: if enable & |eligible: select first eligible queue scanning rr_ptr, rr_ptr+1, ... wrapping at NQ-1 -> 0; grant_qid <= selected; credit <= q_weight[selected]; go SERVE. Otherwise stay IDLE. No q_rd in IDLE.
- SERVE: q_rd[grant_qid] = enable & dst_ready & ~q_empty[grant_qid]. On a read, credit <= credit-1.
- SERVE exit to IDLE, rr_ptr <= grant_qid+1 (wrapping NQ-1 -> 0), when any of: read issued with credit==1; ~enable; q_empty[grant_qid] with no read. dst_ready low alone holds SERVE with credit unchanged.
- Weight sampled only at grant; changes mid-burst apply at the next grant of that queue.
- rd_valid <= |q_rd; rd_qid <= index of asserted q_rd bit (holds previous value when no read).
- Never two q_rd bits high; q_rd never asserted to a queue whose q_empty is high.

## Timing
- Reset values: state IDLE, grant_qid 0, credit 0, rr_ptr 0, busy 0, rd_valid 0, rd_qid 0, q_rd 0.
- Grant latency: eligible queue seen in IDLE at cycle t -> SERVE at t+1 -> first q_rd at t+1 if dst_ready.
- Read-to-data: q_rd at cycle t -> rd_valid/rd_qid at t+1, aligned with registered FIFO read data.
- Back-to-back reads on the granted queue every cycle while dst_ready and non-empty; the registered q_empty reflects the previous read, so no over-read.
- Rotation costs exactly one IDLE bubble between grants; a weight-W burst with ready and data takes W+1 cycles per grant.
- Single eligible queue: regranted to itself after the bubble (scan wraps back to it).
- Queue empties mid-burst: last read at cycle t; at t+1 q_empty high, no read, exit; remaining credit discarded.
- enable low in SERVE: q_rd 0 that cycle, exit next edge. Reset assertion mid-burst: all outputs to reset values immediately (asynchronous); an in-flight rd_valid is dropped.

## Test plan
- Reset, NQ=4, all weights 2, all queues holding 4 entries, dst_ready=1 -> grants 0,1,2,3,0,1,2,3; 2 reads per grant; one idle cycle between grants; 16 reads total, rd_qid sequence 0,0,1,1,2,2,3,3 repeated.
- Weights {3,1,0,2}, all queues full -> queue 2 never read; per round reads 3:1:2 on queues 0,1,3.
- Queue 1 holds 1 entry, weight 4 -> one read, exit on empty, next grant queue 2, credit discarded.
- dst_ready toggled 1,0,0,1 during a weight-3 burst -> reads only in ready cycles, credit held, exactly 3 reads before rotation.
- enable deasserted mid-burst after 1 of 3 reads -> no further q_rd, IDLE next cycle; on re-enable grant starts at grant_qid+1.
- rst_n asserted mid-burst -> q_rd, busy, rd_valid drop to 0 asynchronously; after release, first grant goes to queue 0.
